// File: rtl/lcd_cmd_sequencer.sv
// HD44780-class LCD command sequencer: expands high-level operations into timed
// instruction/data byte transfers for the byte driver and tracks the cursor position.
module lcd_cmd_sequencer #(
    parameter int MODE    = 1,
    parameter int ROWS    = 2,
    parameter int COLS    = 16,
    parameter int WRAP    = 1,
    parameter int T_PWR   = 750000,
    parameter int T_SHORT = 2100,
    parameter int T_LONG  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       drv_valid,
    output logic       drv_rs,
    output logic [7:0] drv_byte,
    input  logic       drv_done,
    output logic       init_done,
    output logic       busy,
    output logic       err,
    output logic [1:0] cur_row,
    output logic [5:0] cur_col
);
    localparam int T_MAX = (T_PWR > T_SHORT) ? ((T_PWR > T_LONG) ? T_PWR : T_LONG)
                                             : ((T_SHORT > T_LONG) ? T_SHORT : T_LONG);
    localparam int CW = $clog2(T_MAX) + 1;
    localparam logic [CW-1:0] LD_PWR   = CW'(T_PWR - 1);
    localparam logic [CW-1:0] LD_SHORT = CW'(T_SHORT - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG - 1);
    localparam logic          DL       = (MODE == 0) ? 1'b1 : 1'b0;
    localparam logic          NL       = (ROWS > 1) ? 1'b1 : 1'b0;
    localparam logic [7:0]    FUNC_SET = {3'b001, DL, NL, 3'b000};

    typedef enum logic [2:0] {S_IDLE, S_PWR_WAIT, S_ISSUE, S_WAIT, S_NEXT} state_t;
    typedef enum logic [2:0] {
        OP_NOP, OP_INIT, OP_CLEAR, OP_HOME, OP_WRITE, OP_SET_ADDR, OP_DISPLAY, OP_SHIFT
    } op_t;
    typedef struct packed {
        logic       long_wait;
        logic       rs;
        logic [7:0] data;
    } xfer_t;

    function automatic logic [6:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    row_base = 7'h00;
            2'd1:    row_base = 7'h40;
            2'd2:    row_base = 7'(COLS);
            default: row_base = 7'(64 + COLS);
        endcase
    endfunction

    // Byte n of a command: INIT uses its fixed table, WRITE may append the wrap address.
    function automatic xfer_t step_xfer(input op_t op, input logic [1:0] step,
                                        input logic [7:0] b0, input logic [7:0] b1);
        step_xfer = '{long_wait: 1'b0, rs: 1'b0, data: b0};
        case (op)
            OP_INIT: begin
                case (step)
                    2'd0:    step_xfer.data = FUNC_SET;
                    2'd1:    step_xfer.data = 8'h0C;
                    2'd2:    step_xfer.data = 8'h06;
                    default: step_xfer = '{long_wait: 1'b1, rs: 1'b0, data: 8'h01};
                endcase
            end
            OP_WRITE: begin
                if (step == 2'd0) step_xfer.rs = 1'b1;
                else              step_xfer.data = b1;
            end
            OP_CLEAR, OP_HOME: step_xfer.long_wait = 1'b1;
            default: ;
        endcase
    endfunction

    state_t        state;
    op_t           op_q;
    logic [1:0]    step_q, last_q, row_q;
    logic [5:0]    col_q;
    logic [7:0]    b0_q, b1_q;
    logic          upd_q, long_q;
    logic [CW-1:0] cnt;

    op_t        op_in;
    logic [1:0] arg_row, row_inc, dec_last, dec_row;
    logic [5:0] arg_col, dec_col;
    logic [7:0] dec_b0, dec_b1;
    logic       dec_upd, illegal;
    xfer_t      launch_x;

    assign op_in   = op_t'(cmd_op);
    assign arg_row = cmd_arg[7:6];
    assign arg_col = cmd_arg[5:0];
    assign row_inc = (int'(cur_row) + 1 >= ROWS) ? 2'd0 : cur_row + 2'd1;
    assign illegal = (!init_done && op_in != OP_NOP && op_in != OP_INIT) ||
                     (op_in == OP_SET_ADDR && (int'(arg_row) >= ROWS || int'(arg_col) >= COLS));
    assign busy    = ~cmd_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave a latch behind.
        dec_b0   = cmd_arg;
        dec_b1   = 8'h80;
        dec_last = 2'd0;
        dec_upd  = 1'b0;
        dec_row  = cur_row;
        dec_col  = cur_col;
        case (op_in)
            OP_INIT, OP_CLEAR, OP_HOME: begin
                dec_last = (op_in == OP_INIT) ? 2'd3 : 2'd0;
                dec_b0   = (op_in == OP_HOME) ? 8'h02 : 8'h01;
                dec_upd  = 1'b1;
                dec_row  = 2'd0;
                dec_col  = 6'd0;
            end
            OP_WRITE: begin
                dec_upd = 1'b1;
                if (int'(cur_col) + 1 < COLS) begin
                    dec_col = cur_col + 6'd1;
                end else if (WRAP != 0) begin
                    dec_row  = row_inc;
                    dec_col  = 6'd0;
                    dec_last = 2'd1;
                    dec_b1   = {1'b1, row_base(row_inc)};
                end
            end
            OP_SET_ADDR: begin
                dec_b0  = {1'b1, row_base(arg_row) + 7'(arg_col)};
                dec_upd = 1'b1;
                dec_row = arg_row;
                dec_col = arg_col;
            end
            OP_DISPLAY: dec_b0 = {5'b00001, cmd_arg[2:0]};
            OP_SHIFT: begin
                dec_b0 = {4'b0001, cmd_arg[1:0], 2'b00};
                if (!cmd_arg[1]) begin
                    dec_upd = 1'b1;
                    if (cmd_arg[0]) dec_col = (int'(cur_col) + 1 < COLS) ? cur_col + 6'd1 : cur_col;
                    else            dec_col = (cur_col == 6'd0) ? cur_col : cur_col - 6'd1;
                end
            end
            default: ;
        endcase
    end

    // Byte loaded into the driver registers whenever the FSM enters ISSUE.
    always_comb begin
        case (state)
            S_IDLE:  launch_x = step_xfer(op_in, 2'd0, dec_b0, dec_b1);
            S_NEXT:  launch_x = step_xfer(op_q, step_q + 2'd1, b0_q, b1_q);
            default: launch_x = step_xfer(op_q, step_q, b0_q, b1_q);
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            drv_valid <= 1'b0;
            drv_rs    <= 1'b0;
            drv_byte  <= 8'h00;
            init_done <= 1'b0;
            err       <= 1'b0;
            cur_row   <= 2'd0;
            cur_col   <= 6'd0;
            op_q      <= OP_NOP;
            step_q    <= 2'd0;
            last_q    <= 2'd0;
            row_q     <= 2'd0;
            col_q     <= 6'd0;
            b0_q      <= 8'h00;
            b1_q      <= 8'h00;
            upd_q     <= 1'b0;
            long_q    <= 1'b0;
            cnt       <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else if (op_in != OP_NOP) begin
                            cmd_ready <= 1'b0;
                            op_q      <= op_in;
                            step_q    <= 2'd0;
                            last_q    <= dec_last;
                            b0_q      <= dec_b0;
                            b1_q      <= dec_b1;
                            upd_q     <= dec_upd;
                            row_q     <= dec_row;
                            col_q     <= dec_col;
                            if (op_in == OP_INIT) begin
                                init_done <= 1'b0;
                                cnt       <= LD_PWR;
                                state     <= S_PWR_WAIT;
                            end else begin
                                drv_valid <= 1'b1;
                                drv_rs    <= launch_x.rs;
                                drv_byte  <= launch_x.data;
                                long_q    <= launch_x.long_wait;
                                state     <= S_ISSUE;
                            end
                        end
                    end
                end
                S_PWR_WAIT: begin
                    if (cnt == '0) begin
                        drv_valid <= 1'b1;
                        drv_rs    <= launch_x.rs;
                        drv_byte  <= launch_x.data;
                        long_q    <= launch_x.long_wait;
                        state     <= S_ISSUE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_ISSUE: begin
                    if (drv_done) begin
                        drv_valid <= 1'b0;
                        cnt       <= long_q ? LD_LONG : LD_SHORT;
                        state     <= S_WAIT;
                        if (step_q == last_q) begin
                            if (upd_q) begin
                                cur_row <= row_q;
                                cur_col <= col_q;
                            end
                            if (op_q == OP_INIT) init_done <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_NEXT;
                    else           cnt   <= cnt - CW'(1);
                end
                S_NEXT: begin
                    if (step_q != last_q) begin
                        step_q    <= step_q + 2'd1;
                        drv_valid <= 1'b1;
                        drv_rs    <= launch_x.rs;
                        drv_byte  <= launch_x.data;
                        long_q    <= launch_x.long_wait;
                        state     <= S_ISSUE;
                    end else begin
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
